// File: rtl/gbuffer_drain_if.sv
// Valid/ready output stream of the global-buffer drain engine.
// The master side is the drain engine, the slave side is the host/DMA consumer.
interface gbuffer_drain_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/gbuffer_drain.sv
// Read-side drain engine: walks the output global buffer in index order and
// streams each word on a valid/ready interface, one word per cycle when ready.
module gbuffer_drain #(
    parameter int WORD_SIZE = 32,
    parameter int ROW_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROW_SIZE:0]    len,
    output logic                 buf_wr_en,
    output logic [ROW_SIZE-1:0]  buf_index,
    input  logic [WORD_SIZE-1:0] buf_data_out,
    gbuffer_drain_if.master      stream,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned       DEPTH_I = 1 << ROW_SIZE;
    localparam logic [ROW_SIZE:0] DEPTH   = DEPTH_I[ROW_SIZE:0];
    localparam logic [ROW_SIZE:0] ONE     = {{ROW_SIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ROW_SIZE:0]    len_q;
    logic [ROW_SIZE:0]    len_eff;
    logic [ROW_SIZE:0]    rd_ptr;
    logic [ROW_SIZE:0]    sent;
    logic [WORD_SIZE-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 handshake;
    logic                 last_beat;
    logic                 next_is_last;

    assign len_eff      = (len > DEPTH) ? DEPTH : len;
    assign handshake    = out_valid_q && stream.out_ready;
    assign last_beat    = (sent == (len_q - ONE));
    assign next_is_last = ((sent + ONE) == (len_q - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_eff == '0) ? DONE : LOAD;
                end
            end
            LOAD:    state_nxt = STREAM;
            STREAM: begin
                if (handshake && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_last is registered with the word it qualifies, so it tracks the
    // value sent will hold once that word is on the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            rd_ptr      <= '0;
            sent        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= len_eff;
                        rd_ptr <= '0;
                        sent   <= '0;
                    end
                end
                LOAD: begin
                    out_data_q  <= buf_data_out;
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_beat;
                    rd_ptr      <= rd_ptr + ONE;
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_beat) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_data_q <= buf_data_out;
                            out_last_q <= next_is_last;
                            rd_ptr     <= rd_ptr + ONE;
                            sent       <= sent + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        buf_index = '0;
        if ((state == LOAD) || (state == STREAM)) begin
            buf_index = rd_ptr[ROW_SIZE-1:0];
        end
    end

    assign buf_wr_en        = 1'b0;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign stream.out_data  = out_data_q;
    assign stream.out_valid = out_valid_q;
    assign stream.out_last  = out_last_q;

endmodule

// File: tb/tb_gbuffer_drain.sv
// Self-checking bench for gbuffer_drain: table of drain cases checked through a
// scoreboard of expected words, plus reset-abort and back-to-back sequences.
module tb_gbuffer_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  len;
    logic        buf_wr_en;
    logic [4:0]  buf_index;
    logic [31:0] buf_data_out;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];

    gbuffer_drain_if #(.WORD_SIZE(32)) sif ();

    gbuffer_drain #(.WORD_SIZE(32), .ROW_SIZE(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .buf_wr_en    (buf_wr_en),
        .buf_index    (buf_index),
        .buf_data_out (buf_data_out),
        .stream       (sif),
        .busy         (busy),
        .done         (done)
    );

    assign buf_data_out = mem[buf_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    typedef struct {
        logic [5:0] l;
        int         mode;
        int         pulse_at;
        int         exp_words;
    } vec_t;

    exp_t q[$];
    vec_t vt[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int first_valid_cyc = -1;
    int done_cyc = -1;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            check("buf_wr_en", {31'd0, buf_wr_en}, 32'd0);
            if (prev_valid && !prev_ready) begin
                check("stall_valid", {31'd0, sif.out_valid}, 32'd1);
                check("stall_data", sif.out_data, prev_data);
                check("stall_last", {31'd0, sif.out_last}, {31'd0, prev_last});
            end
            if (sif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (sif.out_valid && sif.out_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_word", sif.out_data, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word_data", sif.out_data, e.d);
                    check("word_last", {31'd0, sif.out_last}, {31'd0, e.last});
                end
            end
            prev_valid = sif.out_valid;
            prev_ready = sif.out_ready;
            prev_data  = sif.out_data;
            prev_last  = sif.out_last;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        logic [4:0] pat;
        pat = 5'b01001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[k % 5];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called at posedge+1 while the DUT is IDLE; returns at posedge+1 in IDLE.
    task automatic run_drain(input logic [5:0] l, input int mode, input int pulse_at,
                             input int exp_words);
        int t0;
        int k;
        for (int i = 0; i < exp_words; i++) begin
            exp_t e;
            e.d    = 32'h100 + i;
            e.last = (i == exp_words - 1);
            q.push_back(e);
        end
        hs_cnt          = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        sif.out_ready   = ready_for(mode, 0);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 6'd0;
        t0 = cyc;
        k  = 0;
        while (done_cyc < 0 && k < 400) begin
            sif.out_ready = ready_for(mode, k);
            if (k == pulse_at) begin
                start = 1'b1;
                len   = 6'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        check("word_count", hs_cnt, exp_words);
        check("queue_empty", q.size(), 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        if (mode == 0) begin
            if (exp_words == 0) begin
                check("done_latency_len0", done_cyc - t0, 32'd0);
                check("no_valid_len0", first_valid_cyc, 32'hFFFF_FFFF);
            end else begin
                check("first_valid_latency", first_valid_cyc - t0, 32'd1);
                check("done_latency", done_cyc - t0, exp_words + 1);
            end
        end
        q.delete();
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;

        vt[0] = '{l: 6'd32, mode: 0, pulse_at: -1, exp_words: 32};
        vt[1] = '{l: 6'd5,  mode: 1, pulse_at: -1, exp_words: 5};
        vt[2] = '{l: 6'd0,  mode: 0, pulse_at: -1, exp_words: 0};
        vt[3] = '{l: 6'd40, mode: 0, pulse_at: -1, exp_words: 32};
        vt[4] = '{l: 6'd12, mode: 0, pulse_at: 4,  exp_words: 12};
        vt[5] = '{l: 6'd7,  mode: 2, pulse_at: -1, exp_words: 7};
        vt[6] = '{l: 6'd1,  mode: 0, pulse_at: -1, exp_words: 1};

        rst_n = 1'b0;
        start = 1'b0;
        len   = 6'd0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, sif.out_valid}, 32'd0);
        check("rst_last", {31'd0, sif.out_last}, 32'd0);
        check("rst_data", sif.out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_index", {27'd0, buf_index}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_drain(vt[v].l, vt[v].mode, vt[v].pulse_at, vt[v].exp_words);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort a 32-word drain by reset after 10 words have been accepted.
        for (int i = 0; i < 32; i++) begin
            exp_t e;
            e.d    = 32'h100 + i;
            e.last = (i == 31);
            q.push_back(e);
        end
        hs_cnt        = 0;
        sif.out_ready = 1'b1;
        start = 1'b1;
        len   = 6'd32;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs_cnt < 10 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("pre_reset_words", hs_cnt, 32'd10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_valid", {31'd0, sif.out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        check("abort_stays_idle", {31'd0, sif.out_valid | busy}, 32'd0);
        check("abort_word_count", hs_cnt, 32'd10);

        run_drain(6'd3, 0, -1, 3);

        repeat (2) @(posedge clk);
        #1;
        // Back-to-back: second start lands in the first IDLE cycle after DONE.
        run_drain(6'd2, 0, -1, 2);
        run_drain(6'd1, 0, -1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("total_done_pulses", done_cnt, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
